// File: rtl/quad_gen_if.sv
// Control/status bundle for the quadrature generator: the master drives the
// motion request, the slave (generator) returns the A/B channels and status.
interface quad_gen_if #(
  parameter int width     = 8,
  parameter int div_width = 16
);
  logic [div_width-1:0] period;
  logic [width-1:0]     target;
  logic                 load;
  logic                 enable;
  logic                 a;
  logic                 b;
  logic [width-1:0]     position;
  logic                 busy;
  logic                 done;

  modport master (
    output period, target, load, enable,
    input  a, b, position, busy, done
  );

  modport slave (
    input  period, target, load, enable,
    output a, b, position, busy, done
  );
endinterface

// File: rtl/quad_gen.sv
// Quadrature generator: walks position toward a loaded target one quarter-step
// per period, emitting A/B in Gray order so exactly one channel toggles per step.
module quad_gen #(
  parameter int width     = 8,
  parameter int div_width = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  quad_gen_if.slave  bus
);

  logic [width-1:0]     position;
  logic [width-1:0]     target_reg;
  logic [div_width-1:0] timer;
  logic [1:0]           phase;
  logic                 a_q;
  logic                 b_q;
  logic                 done_q;

  logic [div_width-1:0] timer_last;
  logic                 busy;
  logic                 up;
  logic [width-1:0]     next_pos;
  logic [1:0]           next_phase;
  logic [width-1:0]     next_target;
  logic [1:0]           next_ab;

  // Phase index counts up in the forward direction; this maps it onto the
  // (a,b) Gray sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
    logic [1:0] ab;
    ab = 2'b00;
    case (ph)
      2'd0: ab = 2'b00;
      2'd1: ab = 2'b10;
      2'd2: ab = 2'b11;
      2'd3: ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    timer_last  = '0;
    busy        = 1'b0;
    up          = 1'b0;
    next_pos    = position;
    next_phase  = phase;
    next_target = target_reg;
    next_ab     = 2'b00;

    // A period of 0 behaves like 1: step on every comparison.
    if (bus.period != '0)
      timer_last = bus.period - 1'b1;
    busy        = (target_reg != position);
    up          = (target_reg > position);
    next_pos    = up ? position + 1'b1 : position - 1'b1;
    next_phase  = up ? phase + 2'd1 : phase - 2'd1;
    next_target = bus.load ? bus.target : target_reg;
    next_ab     = phase_to_ab(next_phase);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position   <= '0;
      target_reg <= '0;
      timer      <= '0;
      phase      <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load)
        target_reg <= bus.target;

      if (!busy) begin
        timer <= '0;
      end else if (bus.enable) begin
        if (timer >= timer_last) begin
          timer      <= '0;
          position   <= next_pos;
          phase      <= next_phase;
          {a_q, b_q} <= next_ab;
          // Judged against the target that is live next cycle, so a
          // coincident load is honoured.
          done_q     <= (next_pos == next_target);
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.position = position;
  assign bus.busy     = busy;
  assign bus.done     = done_q;

endmodule
